sar_adc_ctrl: RTL and testbench
===============================

// Module: sar_adc_ctrl
// PURPOSE
// - Successive-approximation controller: turns the vdac into an N-bit ADC.
// - Drives trial codes to the vdac, reads back one analog comparator bit
//   (vin vs. vout_ana_) and resolves the code MSB-first.
// - Sits beside vdac in the analog macro; the digital top sees start/valid/data.
// PARAMETERS
// - BITWIDTH       6  conversion width; equals vdac BITWIDTH
// - SETTLE_CYCLES  3  cycles from trial-code apply to decision; legal range >=2
// PORTS
// - i_clk         in   1         system clock
// - i_reset       in   1         asynchronous, active-high reset
// - i_enable      in   1         block enable; low aborts any conversion
// - i_start       in   1         conversion request, sampled in IDLE only
// - i_comp        in   1         raw comparator output; 1 = vin >= vdac out
// - o_dac_data    out  BITWIDTH  trial code to vdac i_data
// - o_dac_enable  out  1         to vdac i_enable
// - o_busy        out  1         high in SETTLE and DONE
// - o_data        out  BITWIDTH  last completed result
// - o_valid       out  1         one-cycle pulse when o_data updates
// BEHAVIOUR
// - One clock; reset is asynchronous and active-high. Reset is i_reset.
// - Reset values: all outputs 0, state IDLE, synchronizer flops 0.
// - The vdac output rises monotonically with o_dac_data read as unsigned.
// - i_comp passes through a 2-flop synchronizer (comp_s) before any use.
// - FSM states: IDLE, SETTLE, DONE.
// - IDLE: o_dac_enable=0, o_dac_data=0. If i_enable and i_start: set
//   o_dac_data = 1<<(BITWIDTH-1), bit index = MSB, cnt = 0, go to SETTLE.
// - SETTLE: o_dac_enable=1. cnt increments each cycle until it reaches
//   SETTLE_CYCLES. On that cycle, the current trial bit stays 1 if comp_s=1,
//   else it clears.
//   - Same edge, if not LSB: set the next-lower bit, cnt=0.
//   - If LSB: register the result into o_data, go to DONE.
// - DONE (1 cycle): o_valid=1, o_dac_enable=1, o_dac_data holds the result;
//   next state IDLE.
// - Latency: i_start edge to o_valid high = 1 + BITWIDTH*(SETTLE_CYCLES+1)
//   cycles; 25 with the defaults. Back-to-back: next i_start is accepted in
//   the IDLE cycle after DONE.
// - i_start is ignored outside IDLE; there is no queueing.
// - i_enable low in SETTLE/DONE: go to IDLE next edge, no o_valid, o_data
//   unchanged.
// - o_data holds its value between conversions; only DONE updates it.
// - Reset asserted mid-conversion: immediate return to the reset values
//   above.
// - The cnt width must be sized for SETTLE_CYCLES with no wrap.
// TESTING (bench comparator model: i_comp = (vin_code >= o_dac_data))
// - vin_code=37, i_start 1-cycle pulse -> o_valid exactly 25 cycles later,
//   o_data=6'b100101; trial sequence 32,48,40,36,38,37.
// - vin_code=0 and vin_code=63 -> o_data=0 and 63; o_valid once each;
//   no X on any output.
// - i_start re-pulsed at cycles 5 and 24 of a conversion -> ignored; exactly
//   one o_valid; a new start one cycle after DONE is accepted.
// - i_enable dropped at cycle 10 -> IDLE next cycle, o_dac_enable=0,
//   no o_valid, previous o_data retained.
// - i_reset asserted mid-SETTLE, asynchronous to i_clk -> all outputs 0
//   before the next edge; a conversion after release returns the correct code.
// - SETTLE_CYCLES=2, vin_code=21 -> o_valid at cycle 19, o_data=21.

Source files
------------

// File: rtl/sar_adc_ctrl_if.sv
// Handshake bundle between the SAR controller, the vdac, the comparator and
// the digital top. The master side is the controller itself; the slave side is
// everything around it (digital top request/response, vdac input, comparator).
interface sar_adc_ctrl_if #(
  parameter int BITWIDTH = 6
);
  logic                i_enable;
  logic                i_start;
  logic                i_comp;
  logic [BITWIDTH-1:0] o_dac_data;
  logic                o_dac_enable;
  logic                o_busy;
  logic [BITWIDTH-1:0] o_data;
  logic                o_valid;

  modport master (
    input  i_enable,
    input  i_start,
    input  i_comp,
    output o_dac_data,
    output o_dac_enable,
    output o_busy,
    output o_data,
    output o_valid
  );

  modport slave (
    output i_enable,
    output i_start,
    output i_comp,
    input  o_dac_data,
    input  o_dac_enable,
    input  o_busy,
    input  o_data,
    input  o_valid
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller. Drives MSB-first trial codes to the
// vdac, waits SETTLE_CYCLES+1 clocks per bit for the vdac and the comparator
// synchronizer to settle, then keeps or clears the trial bit. The resolved
// code is published on o_data with a one-cycle o_valid pulse.
module sar_adc_ctrl #(
  parameter int BITWIDTH      = 6,
  parameter int SETTLE_CYCLES = 3
) (
  input logic            i_clk,
  input logic            i_reset,
  sar_adc_ctrl_if.master bus
);

  // Counter must hold SETTLE_CYCLES itself without wrapping.
  localparam int                  CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [BITWIDTH-1:0] MSB_MASK = {1'b1, {(BITWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt_q;
  logic [BITWIDTH-1:0] mask_q;
  logic [BITWIDTH-1:0] dac_data_q;
  logic                dac_en_q;
  logic                busy_q;
  logic [BITWIDTH-1:0] data_q;
  logic                valid_q;

  logic                comp_p0;
  logic                comp_p1;
  logic                comp_s;
  logic [BITWIDTH-1:0] resolved;

  // Keep the trial bit when the comparator says vin >= vdac, else clear it.
  function automatic logic [BITWIDTH-1:0] resolve_trial(
    input logic [BITWIDTH-1:0] trial,
    input logic [BITWIDTH-1:0] mask,
    input logic                keep
  );
    return keep ? trial : (trial & ~mask);
  endfunction

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      comp_p0 <= 1'b0;
      comp_p1 <= 1'b0;
    end else begin
      // ---- stage p0: first capture, may be metastable ----
      comp_p0 <= bus.i_comp;
      // ---- stage p1: resolved comparator decision ----
      comp_p1 <= comp_p0;
    end
  end

  assign comp_s   = comp_p1;
  assign resolved = resolve_trial(dac_data_q, mask_q, comp_s);

  // Conversion FSM; every output is registered here.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      cnt_q      <= '0;
      mask_q     <= '0;
      dac_data_q <= '0;
      dac_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          dac_en_q   <= 1'b0;
          dac_data_q <= '0;
          busy_q     <= 1'b0;
          if (bus.i_enable && bus.i_start) begin
            state      <= SETTLE;
            dac_data_q <= MSB_MASK;
            mask_q     <= MSB_MASK;
            cnt_q      <= '0;
            dac_en_q   <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        SETTLE: begin
          if (!bus.i_enable) begin
            // Abort: drop back without touching the last result.
            state      <= IDLE;
            cnt_q      <= '0;
            mask_q     <= '0;
            dac_data_q <= '0;
            dac_en_q   <= 1'b0;
            busy_q     <= 1'b0;
          end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + CNT_ONE;
          end else if (mask_q[0]) begin
            // LSB decided: publish the result and hold it on the vdac.
            state      <= DONE;
            dac_data_q <= resolved;
            data_q     <= resolved;
            valid_q    <= 1'b1;
          end else begin
            // Decide this bit and apply the next-lower trial bit.
            dac_data_q <= resolved | (mask_q >> 1);
            mask_q     <= mask_q >> 1;
            cnt_q      <= '0;
          end
        end

        DONE: begin
          state      <= IDLE;
          cnt_q      <= '0;
          mask_q     <= '0;
          dac_data_q <= '0;
          dac_en_q   <= 1'b0;
          busy_q     <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          cnt_q      <= '0;
          mask_q     <= '0;
          dac_data_q <= '0;
          dac_en_q   <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_dac_data   = dac_data_q;
  assign bus.o_dac_enable = dac_en_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_data       = data_q;
  assign bus.o_valid      = valid_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: default instance (6 bits, 3 settle cycles)
// plus a second instance with 2 settle cycles. The comparator is modelled as
// vin_code >= o_dac_data.
module tb_sar_adc_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] vin;
  logic [5:0] vin2;

  sar_adc_ctrl_if #(.BITWIDTH(6)) bus ();
  sar_adc_ctrl_if #(.BITWIDTH(6)) bus2 ();

  sar_adc_ctrl #(.BITWIDTH(6), .SETTLE_CYCLES(3)) u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  sar_adc_ctrl #(.BITWIDTH(6), .SETTLE_CYCLES(2)) u_dut2 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus2)
  );

  assign bus.i_comp  = (vin  >= bus.o_dac_data);
  assign bus2.i_comp = (vin2 >= bus2.o_dac_data);

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         lat_seen;
  int         nval_seen;
  logic [5:0] trace [6];
  logic       xseen;
  logic       en_after_drop;
  logic       busy_after_drop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise i_start in the current cycle (cycle 0) and observe cycles 1..26.
  // rs_a/rs_b re-pulse i_start in those cycles; drop_at lowers i_enable for
  // that one cycle. The call ends in cycle 26 with i_start low.
  task automatic conv(input logic [5:0] code, input int rs_a, input int rs_b, input int drop_at);
    vin       = code;
    lat_seen  = -1;
    nval_seen = 0;
    bus.i_start = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      tick();
      bus.i_start = (c == rs_a) || (c == rs_b);
      if (drop_at >= 0) bus.i_enable = (c != drop_at);
      if (bus.o_valid === 1'b1) begin
        nval_seen++;
        if (lat_seen < 0) lat_seen = c;
      end
      if (((c - 1) % 4 == 0) && ((c - 1) / 4 < 6)) trace[(c - 1) / 4] = bus.o_dac_data;
      if (drop_at >= 0 && c == drop_at + 1) begin
        en_after_drop   = bus.o_dac_enable;
        busy_after_drop = bus.o_busy;
      end
      if ($isunknown({bus.o_dac_data, bus.o_data, bus.o_valid, bus.o_busy, bus.o_dac_enable}))
        xseen = 1'b1;
    end
  endtask

  initial begin
    int lat2;
    int nval2;

    xseen           = 1'b0;
    en_after_drop   = 1'b1;
    busy_after_drop = 1'b1;
    vin             = '0;
    vin2            = '0;
    bus.i_enable    = 1'b0;
    bus.i_start     = 1'b0;
    bus2.i_enable   = 1'b0;
    bus2.i_start    = 1'b0;
    rst             = 1'b1;
    tick();
    tick();

    // Reset values
    check("rst_valid",  {31'd0, bus.o_valid},      32'd0);
    check("rst_data",   {26'd0, bus.o_data},       32'd0);
    check("rst_dac",    {26'd0, bus.o_dac_data},   32'd0);
    check("rst_dac_en", {31'd0, bus.o_dac_enable}, 32'd0);
    check("rst_busy",   {31'd0, bus.o_busy},       32'd0);

    rst = 1'b0;
    tick();
    bus.i_enable = 1'b1;
    tick();

    // vin = 37: latency, result and full trial sequence
    conv(6'd37, -1, -1, -1);
    check("c37_lat",  lat_seen,  32'd25);
    check("c37_data", {26'd0, bus.o_data}, 32'd37);
    check("c37_nval", nval_seen, 32'd1);
    check("c37_t0", {26'd0, trace[0]}, 32'd32);
    check("c37_t1", {26'd0, trace[1]}, 32'd48);
    check("c37_t2", {26'd0, trace[2]}, 32'd40);
    check("c37_t3", {26'd0, trace[3]}, 32'd36);
    check("c37_t4", {26'd0, trace[4]}, 32'd38);
    check("c37_t5", {26'd0, trace[5]}, 32'd37);

    // Back-to-back start one cycle after DONE, bottom of range
    conv(6'd0, -1, -1, -1);
    check("c0_lat",  lat_seen,  32'd25);
    check("c0_data", {26'd0, bus.o_data}, 32'd0);
    check("c0_nval", nval_seen, 32'd1);

    // Top of range
    conv(6'd63, -1, -1, -1);
    check("c63_lat",  lat_seen,  32'd25);
    check("c63_data", {26'd0, bus.o_data}, 32'd63);
    check("c63_nval", nval_seen, 32'd1);
    check("no_x",     {31'd0, xseen}, 32'd0);

    // i_start re-pulsed in cycles 5 and 24 is ignored
    conv(6'd22, 5, 24, -1);
    check("rs_lat",  lat_seen,  32'd25);
    check("rs_nval", nval_seen, 32'd1);
    check("rs_data", {26'd0, bus.o_data}, 32'd22);

    conv(6'd9, -1, -1, -1);
    check("c9_lat",  lat_seen, 32'd25);
    check("c9_data", {26'd0, bus.o_data}, 32'd9);

    // i_enable dropped in cycle 10 aborts; o_data keeps 9
    conv(6'd50, -1, -1, 10);
    check("drop_nval",   nval_seen, 32'd0);
    check("drop_dac_en", {31'd0, en_after_drop},   32'd0);
    check("drop_busy",   {31'd0, busy_after_drop}, 32'd0);
    check("drop_data",   {26'd0, bus.o_data}, 32'd9);

    // Asynchronous reset mid-SETTLE
    vin = 6'd37;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (7) tick();
    check("pre_rst_busy", {31'd0, bus.o_busy}, 32'd1);
    #3 rst = 1'b1;
    #1;
    check("arst_busy",   {31'd0, bus.o_busy},       32'd0);
    check("arst_dac_en", {31'd0, bus.o_dac_enable}, 32'd0);
    check("arst_dac",    {26'd0, bus.o_dac_data},   32'd0);
    check("arst_data",   {26'd0, bus.o_data},       32'd0);
    check("arst_valid",  {31'd0, bus.o_valid},      32'd0);
    #2 rst = 1'b0;
    tick();
    conv(6'd45, -1, -1, -1);
    check("post_rst_lat",  lat_seen, 32'd25);
    check("post_rst_data", {26'd0, bus.o_data}, 32'd45);

    // SETTLE_CYCLES = 2 instance, vin = 21
    bus2.i_enable = 1'b1;
    tick();
    vin2  = 6'd21;
    lat2  = -1;
    nval2 = 0;
    bus2.i_start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick();
      bus2.i_start = 1'b0;
      if (bus2.o_valid === 1'b1) begin
        nval2++;
        if (lat2 < 0) lat2 = c;
      end
    end
    check("s2_lat",  lat2,  32'd19);
    check("s2_nval", nval2, 32'd1);
    check("s2_data", {26'd0, bus2.o_data}, 32'd21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
